clock_ctrl: RTL and testbench
=============================

# clock_ctrl

CPU clock controller sitting directly downstream of the clock divider. It consumes the divider's slow square wave plus a raw step push-button and a raw run/halt switch. From these it produces a single-cycle clock-enable for the 6502 core, in either free-running or single-step mode. All logic runs in the fast board clock domain, and the core is advanced only on `cpu_clk_en` pulses.

## Interface
- `DEBOUNCE_CYCLES`, default 28'd500_000: consecutive stable `clk_in` cycles required before a synchronized button/switch level is accepted (10 ms at 50 MHz).
- `COUNT_W`, default 16: width of the CPU cycle counter.

- `clk_in`  in  1  board clock; sole clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `slow_clk`  in  1  divided clock from the divider, already registered in the `clk_in` domain.
- `step_btn`  in  1  raw step push-button, asynchronous, active-high.
- `run_sw`  in  1  raw run switch, asynchronous; 1 = run, 0 = halt.
- `halt_req`  in  1  synchronous halt request from the core/debug logic; blocks RUN.
- `cpu_clk_en`  out  1  one-`clk_in`-cycle pulse; each pulse advances the CPU one cycle.
- `halted`  out  1  high when the FSM is not in RUN.
- `cycle_count`  out  `COUNT_W`  number of `cpu_clk_en` pulses issued since reset.

## Operation
- **Input synchronizers:** `step_btn` and `run_sw` each pass through a 2-flop synchronizer. Reset value of both flops is 0.
- **Debouncers:** one per input, each with a 28-bit counter.
  - When the synced level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. On reaching `DEBOUNCE_CYCLES-1`, the debounced level takes the synced value and the counter clears.
  - Reset: debounced levels = 0, counters = 0.
- **Step press event:** `step_press` = debounced `step_btn` 0→1, registered edge detect. Lasts one cycle.
- **Slow-clock tick:** `slow_prev` register, reset value 1, so a high `slow_clk` right after reset is not a tick. `tick` = `slow_clk & ~slow_prev`.
- **FSM states:** HALT (reset state), RUN, STEP_WAIT. Transitions are evaluated in this priority order:
  - RUN: if `run_db`==0 or `halt_req`==1, go to HALT with no pulse, even if `tick` is also high that cycle. Otherwise, `tick` → pulse.
  - HALT: if `step_press`, pulse and go to STEP_WAIT (step is allowed even with `halt_req`=1). Else if `run_db`==1 and `halt_req`==0, go to RUN. Ticks are ignored.
  - STEP_WAIT: ticks and presses are ignored. When debounced `step_btn`==0, go to HALT.
- **Pulse output:** "pulse" means `cpu_clk_en` is registered high for exactly the next `clk_in` cycle.
- **Halted flag:** `halted` is registered and equals (next_state != RUN).
- **Cycle counter:** `cycle_count` increments by 1 in the cycle `cpu_clk_en` is high. It wraps from all-ones to 0 with no flag.

## Timing
- Reset values: `cpu_clk_en`=0, `halted`=1, `cycle_count`=0, FSM=HALT.
- Run mode: the rising edge of `slow_clk` is first sampled high in cycle N; `cpu_clk_en` is high in cycle N+1. This gives exactly one pulse per `slow_clk` period.
- Step latency: raw `step_btn` rises in cycle N with a clean input; `step_press` occurs at N+2+`DEBOUNCE_CYCLES`+1 (±1); `cpu_clk_en` follows in the next cycle.
- One press gives exactly one pulse, regardless of how long the button is held or how it bounces.
- Reset mid-operation: a reset asserted in the same cycle as a would-be pulse suppresses it. All state returns to reset values in the following cycle.
- `cpu_clk_en` is never high in two consecutive cycles.

## Configuration
- `CLOCK_CTRL_CYCLE_COUNTER_EN`
  - Defined: the `cycle_count` register and incrementer are built as described above.
  - Undefined: `cycle_count` is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- **Reset:** `DEBOUNCE_CYCLES`=4, assert `reset` 3 cycles with `slow_clk` high → `cpu_clk_en`=0, `halted`=1, `cycle_count`=0, and no pulse in the cycle after release.
- **Run:** `run_sw`=1 held, `slow_clk` period 8 cycles, run 10 periods → exactly 10 pulses, each 1 cycle after a `slow_clk` rise, `halted`=0, `cycle_count`=10.
- **Step debounce:** in HALT, `step_btn` bounces 1-0-1-0-1 at 1-cycle intervals, then held high 20 cycles, then low → exactly 1 pulse; FSM STEP_WAIT→HALT after release is debounced; `cycle_count`=1.
- **Halt priority:** in RUN, assert `halt_req` in the same cycle as a `slow_clk` rise → no pulse, `halted`=1 next cycle. A step press while `halt_req`=1 → 1 pulse.
- **Switch glitch:** `run_sw` pulses high for 2 cycles (< `DEBOUNCE_CYCLES`) → FSM stays HALT, zero pulses.
- **Wrap (macro defined, `COUNT_W`=4):** issue 17 pulses → `cycle_count`=1. With the macro undefined → `cycle_count` stays 0.

Source files
------------

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - CPU clock-enable controller (run/step); cycle counter built only with CLOCK_CTRL_CYCLE_COUNTER_EN
module clock_ctrl #(
  parameter logic [27:0] DEBOUNCE_CYCLES = 28'd500_000,
  parameter int          COUNT_W         = 16
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               slow_clk,
  input  logic               step_btn,
  input  logic               run_sw,
  input  logic               halt_req,
  output logic               cpu_clk_en,
  output logic               halted,
  output logic [COUNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_HALT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic        cpu_clk_en_q;
  logic        halted_q;

  logic        step_meta_q, step_sync_q;
  logic        run_meta_q,  run_sync_q;
  logic [27:0] step_cnt_q,  run_cnt_q;
  logic        step_db_q,   run_db_q;
  logic        step_db_prev_q;
  logic        slow_prev_q;

  logic        step_press;
  logic        tick;

  // Two-flop synchronizers for the asynchronous button and switch.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      run_meta_q  <= 1'b0;
      run_sync_q  <= 1'b0;
    end else begin
      step_meta_q <= step_btn;
      step_sync_q <= step_meta_q;
      run_meta_q  <= run_sw;
      run_sync_q  <= run_meta_q;
    end
  end

  // Step-button debouncer: accept a new level after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      step_cnt_q <= '0;
      step_db_q  <= 1'b0;
    end else if (step_sync_q == step_db_q) begin
      step_cnt_q <= '0;
    end else if (step_cnt_q == DEBOUNCE_CYCLES - 28'd1) begin
      step_db_q  <= step_sync_q;
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_q + 28'd1;
    end
  end

  // Run-switch debouncer, same scheme as the step button.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      run_cnt_q <= '0;
      run_db_q  <= 1'b0;
    end else if (run_sync_q == run_db_q) begin
      run_cnt_q <= '0;
    end else if (run_cnt_q == DEBOUNCE_CYCLES - 28'd1) begin
      run_db_q  <= run_sync_q;
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_q + 28'd1;
    end
  end

  // Edge-detect history; slow_prev resets high so a slow_clk already high after reset is not a tick.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      step_db_prev_q <= 1'b0;
      slow_prev_q    <= 1'b1;
    end else begin
      step_db_prev_q <= step_db_q;
      slow_prev_q    <= slow_clk;
    end
  end

  assign step_press = step_db_q & ~step_db_prev_q;
  assign tick       = slow_clk & ~slow_prev_q;

  // Run/halt/step FSM with registered pulse and halted flag (halted tracks the next state).
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= ST_HALT;
      cpu_clk_en_q <= 1'b0;
      halted_q     <= 1'b1;
    end else begin
      cpu_clk_en_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (!run_db_q || halt_req) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            halted_q <= 1'b0;
            if (tick) cpu_clk_en_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (step_press) begin
            state_q      <= ST_STEP_WAIT;
            cpu_clk_en_q <= 1'b1;
            halted_q     <= 1'b1;
          end else if (run_db_q && !halt_req) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else begin
            halted_q <= 1'b1;
          end
        end
        ST_STEP_WAIT: begin
          if (!step_db_q) state_q <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_clk_en = cpu_clk_en_q;
  assign halted     = halted_q;

`ifdef CLOCK_CTRL_CYCLE_COUNTER_EN
  logic [COUNT_W-1:0] count_q;

  // Count issued CPU cycles; wraps silently.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= '0;
    end else if (cpu_clk_en_q) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - self-checking bench for clock_ctrl
module tb_clock_ctrl;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       slow_clk;
  logic       step_btn;
  logic       run_sw;
  logic       halt_req;
  logic       cpu_clk_en;
  logic       halted;
  logic [3:0] cycle_count;

  always #5 clk_in = ~clk_in;

  clock_ctrl #(
    .DEBOUNCE_CYCLES(28'd4),
    .COUNT_W        (4)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .step_btn   (step_btn),
    .run_sw     (run_sw),
    .halt_req   (halt_req),
    .cpu_clk_en (cpu_clk_en),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  typedef struct {
    int lo;
    int hi;
  } win_t;

  win_t exp_q[$];
  int   cyc        = 0;
  int   errors     = 0;
  int   checks     = 0;
  int   exp_pulses = 0;
  logic prev_en    = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_count();
`ifdef CLOCK_CTRL_CYCLE_COUNTER_EN
    logic [31:0] p;
    p = exp_pulses;
    return p[3:0];
`else
    return 4'd0;
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push(input int lo, input int hi);
    win_t w;
    w.lo = lo;
    w.hi = hi;
    exp_q.push_back(w);
    exp_pulses++;
  endtask

  task automatic slow_period(input bit expect_pulse);
    slow_clk = 1'b1;
    if (expect_pulse) push(cyc + 1, cyc + 1);
    cycles(4);
    slow_clk = 1'b0;
    cycles(4);
  endtask

  // Pulse monitor: every observed pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (cpu_clk_en === 1'b1) begin
      win_t w;
      chk("no_back_to_back", {31'd0, prev_en}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("pulse_timing", {31'd0, (cyc >= w.lo) && (cyc <= w.hi)}, 32'd1);
      end
    end
    prev_en = cpu_clk_en;
  end

  initial begin
    reset    = 1'b1;
    slow_clk = 1'b1;
    step_btn = 1'b0;
    run_sw   = 1'b0;
    halt_req = 1'b0;

    // Reset held 3 cycles with slow_clk high.
    cycles(1);
    chk("rst_en", {31'd0, cpu_clk_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_count", {28'd0, cycle_count}, 32'd0);
    cycles(2);
    reset = 1'b0;
    cycles(1);
    chk("post_rst_no_pulse", {31'd0, cpu_clk_en}, 32'd0);
    chk("post_rst_halted", {31'd0, halted}, 32'd1);
    slow_clk = 1'b0;
    cycles(2);

    // Free-running: 10 slow_clk periods.
    run_sw = 1'b1;
    cycles(12);
    chk("run_entered", {31'd0, halted}, 32'd0);
    repeat (10) slow_period(1'b1);
    cycles(2);
    chk("run_count", {28'd0, cycle_count}, {28'd0, exp_count()});
    chk("run_halted", {31'd0, halted}, 32'd0);
    chk("run_all_pulses", exp_q.size(), 32'd0);

    // halt_req in the same cycle as a slow_clk rise: no pulse, halted next cycle.
    halt_req = 1'b1;
    slow_clk = 1'b1;
    cycles(1);
    chk("halt_prio_halted", {31'd0, halted}, 32'd1);
    cycles(3);
    slow_clk = 1'b0;
    cycles(4);
    // Step is still allowed while halt_req is high.
    step_btn = 1'b1;
    push(cyc + 5, cyc + 10);
    cycles(12);
    step_btn = 1'b0;
    cycles(12);
    chk("halt_step_pulse", exp_q.size(), 32'd0);
    chk("halt_step_count", {28'd0, cycle_count}, {28'd0, exp_count()});
    run_sw = 1'b0;
    cycles(10);
    halt_req = 1'b0;
    cycles(2);
    chk("halt_back", {31'd0, halted}, 32'd1);

    // Bouncing step press: exactly one pulse.
    step_btn = 1'b1; cycles(1);
    step_btn = 1'b0; cycles(1);
    step_btn = 1'b1; cycles(1);
    step_btn = 1'b0; cycles(1);
    step_btn = 1'b1;
    push(cyc + 5, cyc + 10);
    cycles(20);
    step_btn = 1'b0;
    // Ticks while held/releasing must be ignored.
    slow_period(1'b0);
    cycles(4);
    chk("bounce_one_pulse", exp_q.size(), 32'd0);
    chk("bounce_count", {28'd0, cycle_count}, {28'd0, exp_count()});
    // A fresh press proves the FSM returned to HALT after release.
    step_btn = 1'b1;
    push(cyc + 5, cyc + 10);
    cycles(12);
    step_btn = 1'b0;
    cycles(12);
    chk("repress_pulse", exp_q.size(), 32'd0);
    chk("repress_count", {28'd0, cycle_count}, {28'd0, exp_count()});

    // Short run_sw glitch must not leave HALT.
    run_sw = 1'b1;
    cycles(2);
    run_sw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slow_period(1'b0);
      chk("glitch_halted", {31'd0, halted}, 32'd1);
    end
    chk("glitch_count", {28'd0, cycle_count}, {28'd0, exp_count()});

    // Reset in the cycle of a would-be pulse suppresses it.
    run_sw = 1'b1;
    cycles(12);
    chk("rerun_entered", {31'd0, halted}, 32'd0);
    slow_period(1'b1);
    slow_period(1'b1);
    slow_clk = 1'b1;
    reset    = 1'b1;
    cycles(1);
    chk("midrst_en", {31'd0, cpu_clk_en}, 32'd0);
    chk("midrst_halted", {31'd0, halted}, 32'd1);
    chk("midrst_count", {28'd0, cycle_count}, 32'd0);
    exp_pulses = 0;
    cycles(1);
    reset    = 1'b0;
    slow_clk = 1'b0;
    cycles(12);
    chk("wrap_run_entered", {31'd0, halted}, 32'd0);

    // 17 pulses on a 4-bit counter wrap to 1.
    repeat (17) slow_period(1'b1);
    cycles(2);
    chk("wrap_count", {28'd0, cycle_count}, {28'd0, exp_count()});
    chk("wrap_all_pulses", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
